// File: rtl/drg_pkg.sv
// Shared encodings for the digital ramp generator: sweep modes and FSM states.
package drg_pkg;

    typedef enum logic [1:0] {
        MODE_SAW        = 2'd0,
        MODE_TRI        = 2'd1,
        MODE_SINGLE     = 2'd2,
        MODE_SINGLE_TRI = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/drg_step_unit.sv
// Combinational next-value logic for one ramp step; all compares are W+1 bits
// so a step past the top of the W-bit range is seen as "beyond end", never wrapped.
module drg_step_unit
    import drg_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_start,
    input  logic [W-1:0] i_end,
    input  logic [W-1:0] i_step,
    input  logic         i_dir,
    input  mode_e        i_mode,
    output logic [W-1:0] o_nxt,
    output logic         o_turn,
    output logic         o_wrap,
    output logic         o_finish
);

    logic [W:0] w_cur_x;
    logic [W:0] w_end_x;
    logic [W:0] w_sum;
    logic [W:0] w_lo;

    assign w_cur_x = {1'b0, i_cur};
    assign w_end_x = {1'b0, i_end};
    assign w_sum   = w_cur_x + {1'b0, i_step};
    assign w_lo    = {1'b0, i_start} + {1'b0, i_step};

    always_comb begin
        o_nxt    = w_sum[W-1:0];
        o_turn   = 1'b0;
        o_wrap   = 1'b0;
        o_finish = 1'b0;
        if (i_dir) begin
            // Descending: land exactly on start rather than stepping below it.
            if (w_cur_x < w_lo) begin
                o_nxt = i_start;
                if (i_mode == MODE_SINGLE_TRI) o_finish = 1'b1;
                else                           o_wrap   = 1'b1;
            end else begin
                o_nxt = i_cur - i_step;
            end
        end else begin
            case (i_mode)
                MODE_SAW: begin
                    if (w_sum > w_end_x) begin
                        o_nxt  = i_start;
                        o_wrap = 1'b1;
                    end
                end
                MODE_SINGLE: begin
                    if (w_sum >= w_end_x) begin
                        o_nxt    = i_end;
                        o_finish = 1'b1;
                    end
                end
                default: begin
                    if (w_sum >= w_end_x) begin
                        o_nxt  = i_end;
                        o_turn = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/drg_sweep.sv
// Digital ramp generator: shadowed sweep parameters, dwell counter and
// IDLE/UP/DOWN sweep FSM feeding the DDS tuning word.
module drg_sweep
    import drg_pkg::*;
#(
    parameter int W  = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          param_write,
    input  logic [W-1:0]  cfg_start,
    input  logic [W-1:0]  cfg_end,
    input  logic [W-1:0]  cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic          start,
    input  logic          stop,
    input  logic          tick,
    output logic [W-1:0]  drg_output,
    output logic          out_update,
    output logic          busy,
    output logic          dir,
    output logic          sweep_done,
    output logic          cfg_pending,
    output logic          cfg_err
);

    state_e        r_state, w_state_nx;
    logic [W-1:0]  r_sh_start, r_sh_end, r_sh_step;
    logic [W-1:0]  r_act_start, r_act_end, r_act_step;
    logic [DW-1:0] r_sh_dwell, r_act_dwell, r_dwell_cnt;
    mode_e         r_sh_mode, r_act_mode;
    logic [W-1:0]  r_out;
    logic          r_upd, r_dir, r_done, r_pending, r_err;

    logic          w_busy, w_sh_valid, w_step_due;
    logic          w_launch, w_step, w_commit, w_err_set, w_cnt_inc;
    logic [W-1:0]  w_nxt;
    logic          w_turn, w_wrap, w_finish;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_sh_valid = (r_sh_start < r_sh_end) && (r_sh_step != '0);
    assign w_step_due = w_busy && tick && (r_dwell_cnt == r_act_dwell);

    drg_step_unit #(.W(W)) u_step (
        .i_cur    (r_out),
        .i_start  (r_act_start),
        .i_end    (r_act_end),
        .i_step   (r_act_step),
        .i_dir    (r_dir),
        .i_mode   (r_act_mode),
        .o_nxt    (w_nxt),
        .o_turn   (w_turn),
        .o_wrap   (w_wrap),
        .o_finish (w_finish)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    // Priority: stop, then start (restart if busy), then a dwell-completing tick.
    always_comb begin
        w_state_nx = r_state;
        w_launch   = 1'b0;
        w_step     = 1'b0;
        w_commit   = 1'b0;
        w_err_set  = 1'b0;
        w_cnt_inc  = 1'b0;
        if (stop) begin
            w_state_nx = ST_IDLE;
        end else if (start) begin
            if (w_sh_valid) begin
                w_launch   = 1'b1;
                w_commit   = 1'b1;
                w_state_nx = ST_UP;
            end else begin
                w_err_set  = 1'b1;
                w_state_nx = ST_IDLE;
            end
        end else if (w_step_due) begin
            w_step   = 1'b1;
            w_commit = w_wrap;
            if (w_finish)    w_state_nx = ST_IDLE;
            else if (w_turn) w_state_nx = ST_DOWN;
            else if (w_wrap) w_state_nx = ST_UP;
        end else if (w_busy && tick) begin
            w_cnt_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_start  <= '0;
            r_sh_end    <= '0;
            r_sh_step   <= '0;
            r_sh_dwell  <= '0;
            r_sh_mode   <= MODE_SAW;
            r_act_start <= '0;
            r_act_end   <= '0;
            r_act_step  <= '0;
            r_act_dwell <= '0;
            r_act_mode  <= MODE_SAW;
            r_dwell_cnt <= '0;
            r_out       <= '0;
            r_upd       <= 1'b0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
            r_pending   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (param_write) begin
                r_sh_start <= cfg_start;
                r_sh_end   <= cfg_end;
                r_sh_step  <= cfg_step;
                r_sh_dwell <= cfg_dwell;
                r_sh_mode  <= mode_e'(cfg_mode);
            end
            // Commit sees the pre-write shadow, so a coincident write stays pending.
            if (w_commit) begin
                r_act_start <= r_sh_start;
                r_act_end   <= r_sh_end;
                r_act_step  <= r_sh_step;
                r_act_dwell <= r_sh_dwell;
                r_act_mode  <= r_sh_mode;
            end
            if (param_write)   r_pending <= 1'b1;
            else if (w_commit) r_pending <= 1'b0;

            if (w_err_set)        r_err <= 1'b1;
            else if (param_write) r_err <= 1'b0;

            r_upd  <= w_launch | w_step;
            r_done <= w_step & (w_wrap | w_finish);

            if (w_launch) begin
                r_out       <= r_sh_start;
                r_dir       <= 1'b0;
                r_dwell_cnt <= '0;
            end else if (w_step) begin
                r_out       <= w_nxt;
                r_dwell_cnt <= '0;
                if (w_turn)                r_dir <= 1'b1;
                else if (w_wrap | w_finish) r_dir <= 1'b0;
            end else if (w_cnt_inc) begin
                r_dwell_cnt <= r_dwell_cnt + DW'(1);
            end
        end
    end

    assign drg_output  = r_out;
    assign out_update  = r_upd;
    assign busy        = w_busy;
    assign dir         = r_dir;
    assign sweep_done  = r_done;
    assign cfg_pending = r_pending;
    assign cfg_err     = r_err;

endmodule

// File: tb/tb_drg_sweep.sv
// Directed vector bench for drg_sweep: one table row per clock edge,
// plus a hand-written dwell/single-shot latency sequence.
module tb_drg_sweep;

    localparam int W  = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, param_write, start, stop, tick;
    logic [W-1:0]  cfg_start, cfg_end, cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic [W-1:0]  drg_output;
    logic          out_update, busy, dir, sweep_done, cfg_pending, cfg_err;

    always #5 clk = ~clk;

    drg_sweep #(.W(W), .DW(DW)) dut (
        .clk(clk), .rst(rst), .param_write(param_write),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .start(start), .stop(stop), .tick(tick),
        .drg_output(drg_output), .out_update(out_update), .busy(busy),
        .dir(dir), .sweep_done(sweep_done), .cfg_pending(cfg_pending),
        .cfg_err(cfg_err)
    );

    // Expected flags packed as {out_update, busy, dir, sweep_done, cfg_pending, cfg_err}.
    typedef struct packed {
        logic          r, pw, st, sp, tk;
        logic [W-1:0]  cs, ce, cst;
        logic [DW-1:0] dw;
        logic [1:0]    md;
        logic [W-1:0]  eo;
        logic [5:0]    ef;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t v(input int r, pw, st, sp, tk, cs, ce, cst, dw, md, eo, ef);
        vec_t x;
        x.r = 1'(r); x.pw = 1'(pw); x.st = 1'(st); x.sp = 1'(sp); x.tk = 1'(tk);
        x.cs = W'(cs); x.ce = W'(ce); x.cst = W'(cst); x.dw = DW'(dw); x.md = 2'(md);
        x.eo = W'(eo); x.ef = 6'(ef);
        return x;
    endfunction

    function automatic vec_t tt(input int eo, ef);
        return v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, eo, ef);
    endfunction

    function automatic vec_t cfg(input int cs, ce, cst, dw, md, eo, ef);
        return v(0, 1, 0, 0, 0, cs, ce, cst, dw, md, eo, ef);
    endfunction

    function automatic vec_t ctl(input int r, st, sp, tk, eo, ef);
        return v(r, 0, st, sp, tk, 0, 0, 0, 0, 0, eo, ef);
    endfunction

    task automatic apply(input vec_t x, input int idx);
        rst = x.r; param_write = x.pw; start = x.st; stop = x.sp; tick = x.tk;
        cfg_start = x.cs; cfg_end = x.ce; cfg_step = x.cst; cfg_dwell = x.dw; cfg_mode = x.md;
        @(posedge clk);
        #1;
        nvec++;
        if ({drg_output, out_update, busy, dir, sweep_done, cfg_pending, cfg_err} !== {x.eo, x.ef}) begin
            nerr++;
            $display("FAIL vec%0d: got out=%h flags=%b, want out=%h flags=%b (upd,busy,dir,done,pend,err)",
                     idx, drg_output, {out_update, busy, dir, sweep_done, cfg_pending, cfg_err}, x.eo, x.ef);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; param_write = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;

        // reset, then saw 10/40/10
        tbl.push_back(ctl(1, 0, 0, 0, 0, 6'b000000));
        tbl.push_back(cfg(10, 40, 10, 0, 0, 0, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 10, 6'b110000));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(tt(30, 6'b110000));
        tbl.push_back(tt(40, 6'b110000));
        tbl.push_back(tt(10, 6'b110100));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(ctl(0, 0, 1, 1, 20, 6'b000000));
        // triangle 0/25/10
        tbl.push_back(cfg(0, 25, 10, 0, 1, 20, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 0, 6'b110000));
        tbl.push_back(tt(10, 6'b110000));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(tt(25, 6'b111000));
        tbl.push_back(tt(15, 6'b111000));
        tbl.push_back(tt(5, 6'b111000));
        tbl.push_back(tt(0, 6'b110100));
        tbl.push_back(tt(10, 6'b110000));
        tbl.push_back(ctl(0, 0, 1, 1, 10, 6'b000000));
        // overflow guard
        tbl.push_back(cfg(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h10, 0, 0, 10, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 32'hFFFFFFF0, 6'b110000));
        tbl.push_back(tt(32'hFFFFFFF0, 6'b110100));
        tbl.push_back(tt(32'hFFFFFFF0, 6'b110100));
        tbl.push_back(tt(32'hFFFFFFF0, 6'b110100));
        tbl.push_back(ctl(0, 0, 1, 1, 32'hFFFFFFF0, 6'b000000));
        // dwell 2, tick every cycle then every second cycle
        tbl.push_back(cfg(0, 30, 10, 2, 0, 32'hFFFFFFF0, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 0, 6'b110000));
        tbl.push_back(tt(0, 6'b010000));
        tbl.push_back(tt(0, 6'b010000));
        tbl.push_back(tt(10, 6'b110000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(ctl(0, 0, 0, i % 2, 10, 6'b010000));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(ctl(0, 0, 1, 1, 20, 6'b000000));
        // shadow commit: end 30 -> 50 -> 20, second write lands on a commit cycle
        tbl.push_back(cfg(0, 30, 10, 0, 0, 20, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 0, 6'b110000));
        tbl.push_back(tt(10, 6'b110000));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 50, 10, 0, 0, 20, 6'b110010));
        tbl.push_back(tt(30, 6'b110010));
        tbl.push_back(tt(0, 6'b110100));
        for (int i = 1; i <= 5; i++) tbl.push_back(tt(10 * i, 6'b110000));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 20, 10, 0, 0, 0, 6'b110110));
        for (int i = 1; i <= 5; i++) tbl.push_back(tt(10 * i, 6'b110010));
        tbl.push_back(tt(0, 6'b110100));
        tbl.push_back(tt(10, 6'b110000));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(tt(0, 6'b110100));
        tbl.push_back(ctl(0, 0, 1, 1, 0, 6'b000000));
        // single up: stop at 20, then natural completion
        tbl.push_back(cfg(0, 50, 10, 0, 2, 0, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 0, 6'b110000));
        tbl.push_back(tt(10, 6'b110000));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(ctl(0, 0, 1, 1, 20, 6'b000000));
        tbl.push_back(tt(20, 6'b000000));
        tbl.push_back(cfg(0, 25, 10, 0, 2, 20, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 0, 6'b110000));
        tbl.push_back(tt(10, 6'b110000));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(tt(25, 6'b100100));
        tbl.push_back(tt(25, 6'b000000));
        // single triangle: a mid-sweep write must stay pending through the finish
        tbl.push_back(cfg(0, 25, 10, 0, 3, 25, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 1, 0, 6'b110000));
        tbl.push_back(tt(10, 6'b110000));
        tbl.push_back(tt(20, 6'b110000));
        tbl.push_back(tt(25, 6'b111000));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 40, 10, 0, 3, 15, 6'b111010));
        tbl.push_back(tt(5, 6'b111010));
        tbl.push_back(tt(0, 6'b100110));
        tbl.push_back(tt(0, 6'b000010));
        // refused starts, start+stop, restart while busy, reset mid-sweep
        tbl.push_back(cfg(0, 30, 0, 0, 0, 0, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 0, 0, 6'b000011));
        tbl.push_back(cfg(5, 30, 10, 0, 0, 0, 6'b000010));
        tbl.push_back(ctl(0, 1, 1, 0, 0, 6'b000010));
        tbl.push_back(cfg(30, 30, 10, 0, 0, 0, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 0, 0, 6'b000011));
        tbl.push_back(cfg(5, 30, 10, 0, 0, 0, 6'b000010));
        tbl.push_back(ctl(0, 1, 0, 0, 5, 6'b110000));
        tbl.push_back(tt(15, 6'b110000));
        tbl.push_back(ctl(0, 1, 0, 1, 5, 6'b110000));
        tbl.push_back(tt(15, 6'b110000));
        tbl.push_back(ctl(1, 0, 0, 1, 0, 6'b000000));
        tbl.push_back(ctl(0, 1, 0, 0, 0, 6'b000001));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Single up 0/30/10 with dwell 3: each value lasts 4 ticks, so 30 arrives 12 edges after launch.
        rst = 1'b0; stop = 1'b0; start = 1'b0; tick = 1'b0;
        param_write = 1'b1; cfg_start = 0; cfg_end = 30; cfg_step = 10; cfg_dwell = 3; cfg_mode = 2;
        @(posedge clk); #1;
        param_write = 1'b0; start = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nvec++;
        if (drg_output !== 0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL seq_launch: got out=%0d busy=%b, want out=0 busy=1", drg_output, busy);
        end
        n = 0;
        while (sweep_done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        nvec++;
        if (n != 12 || drg_output !== 30 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL seq_dwell_done: got edges=%0d out=%0d busy=%b, want edges=12 out=30 busy=0",
                     n, drg_output, busy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/drg_sweep.md
# drg_sweep

Parametrised digital ramp generator: next generation of the DDS sweep source. Produces a W-bit ramp, the frequency/phase tuning word, from start to end in programmable steps. Supports four sweep modes, a per-step dwell count, a `tick` advance strobe and shadowed parameters that commit only at sweep boundaries. The block sits between the register interface and the DDS phase accumulator, and runs entirely in the DDS clock domain.

## Interface
- `W`, 32: ramp/output width.
- `DW`, 16: dwell counter width.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `param_write` in 1: one-cycle strobe; loads `cfg_*` into the shadow registers.
- `cfg_start` in W: sweep start value.
- `cfg_end` in W: sweep end value, inclusive.
- `cfg_step` in W: step magnitude.
- `cfg_dwell` in DW: extra ticks to hold each value.
- `cfg_mode` in 2: 0 saw, 1 triangle, 2 single up, 3 single triangle.
- `start` in 1: pulse; begins a sweep.
- `stop` in 1: pulse; halts the sweep.
- `tick` in 1: advance enable, e.g. the DDS sample strobe.
- `drg_output` out W: ramp value, registered.
- `out_update` out 1: pulse; `drg_output` changed this cycle.
- `busy` out 1: FSM is not in IDLE.
- `dir` out 1: 0 up, 1 down.
- `sweep_done` out 1: pulse at each completed sweep or period.
- `cfg_pending` out 1: shadow holds values not yet committed.
- `cfg_err` out 1: sticky; last `start` was refused.

## Operation
- Reset values: all shadow/active registers 0, FSM IDLE, `drg_output` 0, all flags 0.
- Register sets:
  - `param_write` copies the `cfg_*` inputs into the shadow set and sets `cfg_pending`. It also clears `cfg_err`.
  - Commit copies shadow to active and clears `cfg_pending`. Commit happens on `start` and at every sweep boundary.
  - If `param_write` and a commit fall in the same cycle, the commit takes the old shadow and `cfg_pending` stays 1.
- Validity: on `start`, the shadow is invalid if `start >= end` or `step == 0`. In that case the FSM stays or returns to IDLE, sets `cfg_err`, and does not commit.
- FSM states: IDLE, UP, DOWN.
  - IDLE -> UP on a valid `start`.
  - UP -> DOWN at the end turn (modes 1 and 3).
  - DOWN -> UP at the start turn (mode 1).
  - UP or DOWN -> IDLE on single-shot completion or `stop`.
  - `stop` wins over `start`. `start` while busy restarts from the start value, with a commit.
- Dwell: `dwell_cnt` increments on `tick` while busy. When `dwell_cnt == dwell`, the block steps and `dwell_cnt` returns to 0. Each value is therefore held `dwell+1` ticks. `dwell_cnt` clears on `start`.
- Arithmetic: all sums are W+1 bits, so there is never modular overflow.
  - Up: `nxt = cur + step`.
  - Down: if `cur < start + step`, the result is the start turn; otherwise `cur - step`.
- Mode 0 (saw):
  - If `nxt > end`: output `start`, commit, pulse `sweep_done`.
  - Otherwise output `nxt`. A value exactly equal to `end` is emitted.
- Mode 1 (triangle):
  - Up, `nxt >= end`: output `end`, `dir <= 1`.
  - Down, start turn: output `start`, `dir <= 0`, commit, pulse `sweep_done`.
- Mode 2 (single up): `nxt >= end` -> output `end`, go IDLE, pulse `sweep_done`. The output holds.
- Mode 3 (single triangle): as mode 1, but the start turn goes to IDLE and does not commit.
- `stop`: go IDLE and keep `drg_output` as is. No `sweep_done` pulse.
- `rst` mid-sweep: everything returns to reset values on the next edge.

## Timing
- `start` sampled at edge t:
  - At t+1: `drg_output = start`, `busy = 1`, `dir = 0`, `out_update = 1`.
  - The first step needs `dwell+1` ticks after t+1.
- Step latency: a `tick` at edge t that completes a dwell gives the new value and `out_update` at t+1.
- `sweep_done` is high for exactly the cycle in which `drg_output` shows the boundary value.
- `busy` falls in the same cycle that the final value, or the held value after `stop`, is presented.
- `tick` is ignored in IDLE and in the `start` cycle itself.

## Structure
- Shared package `drg_pkg`:
  - Mode encodings `MODE_SAW/TRI/SINGLE/SINGLE_TRI`.
  - State encodings `ST_IDLE/UP/DOWN`.
- Sub-module `drg_step_unit` (combinational):
  - Inputs: `cur`, `start`, `end`, `step`, `dir`, `mode`.
  - Outputs: next value, `turn`, `wrap`, `finish` flags.
  - Keeps the W+1 compare logic separate from the FSM/dwell/shadow logic in `drg_sweep`.

## Test plan
- Saw, 10/40/10, dwell 0, `tick` every cycle -> output 10,20,30,40,10,20…; `sweep_done` with each 10 after the first.
- Triangle, 0/25/10 -> output 0,10,20,25,15,5,0,10; `dir` 1 from 25 through 5; `sweep_done` at the 0.
- Overflow guard, saw, start 0xFFFFFFF0, end 0xFFFFFFFF, step 0x10 -> output stays 0xFFFFFFF0, `sweep_done` on every step, never 0x0.
- Dwell 2, saw, 0/30/10 -> each value lasts 3 ticks; with `tick` every second cycle, each value lasts 6 cycles.
- Shadow commit: saw 0/30/10 running, `param_write` end=50 at output 10 -> `cfg_pending=1`, outputs continue 20,30,0; then 40,50 appear and `cfg_pending=0` at the wrap.
- Errors and control:
  - `start` with step=0 -> `cfg_err=1`, `busy=0`.
  - `stop` at output 20, mode 2 -> output holds 20, no `sweep_done`.
  - `start`+`stop` in the same cycle -> stays IDLE.
  - `rst` mid-sweep -> output 0.
